// File: rtl/axis_frame_gen.sv
// AXI-Stream frame generator: accepts a command and emits a frame of len beats with an
// incrementing byte-wrapped payload starting at seed, plus completion and error status.
module axis_frame_gen #(
    parameter int DATA_WIDTH = 8,
    parameter int KEEP_WIDTH = DATA_WIDTH / 8,
    parameter int ID_WIDTH   = 8,
    parameter int DEST_WIDTH = 8,
    parameter int LEN_WIDTH  = 16,
    parameter int CNT_WIDTH  = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [LEN_WIDTH-1:0]  cmd_len,
    input  logic [DATA_WIDTH-1:0] cmd_seed,
    input  logic [ID_WIDTH-1:0]   cmd_id,
    input  logic [DEST_WIDTH-1:0] cmd_dest,
    input  logic                  cmd_bad,
    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic [KEEP_WIDTH-1:0] m_axis_tkeep,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready,
    output logic                  m_axis_tlast,
    output logic [ID_WIDTH-1:0]   m_axis_tid,
    output logic [DEST_WIDTH-1:0] m_axis_tdest,
    output logic                  m_axis_tuser,
    output logic                  busy,
    output logic                  status_frame_done,
    output logic                  status_len_error,
    output logic [CNT_WIDTH-1:0]  frame_count
);

    typedef enum logic {IDLE, SEND} state_t;

    state_t                state_q, state_d;
    logic [LEN_WIDTH-1:0]  len_q, len_d;
    logic [LEN_WIDTH-1:0]  beat_q, beat_d;
    logic                  bad_q, bad_d;
    logic                  tvalid_q, tvalid_d;
    logic                  tlast_q, tlast_d;
    logic                  tuser_q, tuser_d;
    logic [DATA_WIDTH-1:0] tdata_q, tdata_d;
    logic [ID_WIDTH-1:0]   tid_q, tid_d;
    logic [DEST_WIDTH-1:0] tdest_q, tdest_d;
    logic                  done_q, done_d;
    logic                  len_err_q, len_err_d;
    logic [CNT_WIDTH-1:0]  count_q, count_d;
    logic [LEN_WIDTH-1:0]  beat_next;

    assign beat_next = beat_q + LEN_WIDTH'(1);

    always_comb begin
        state_d   = state_q;
        len_d     = len_q;
        beat_d    = beat_q;
        bad_d     = bad_q;
        tvalid_d  = tvalid_q;
        tlast_d   = tlast_q;
        tuser_d   = tuser_q;
        tdata_d   = tdata_q;
        tid_d     = tid_q;
        tdest_d   = tdest_q;
        done_d    = 1'b0;
        len_err_d = 1'b0;
        count_d   = count_q;
        case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    if (cmd_len != '0) begin
                        state_d  = SEND;
                        len_d    = cmd_len;
                        beat_d   = '0;
                        bad_d    = cmd_bad;
                        tvalid_d = 1'b1;
                        tdata_d  = cmd_seed;
                        tid_d    = cmd_id;
                        tdest_d  = cmd_dest;
                        // A single-beat frame is its own last beat.
                        tlast_d  = (cmd_len == LEN_WIDTH'(1));
                        tuser_d  = cmd_bad && (cmd_len == LEN_WIDTH'(1));
                    end else begin
                        len_err_d = 1'b1;
                    end
                end
            end
            SEND: begin
                if (m_axis_tready) begin
                    if (tlast_q) begin
                        state_d  = IDLE;
                        tvalid_d = 1'b0;
                        tlast_d  = 1'b0;
                        tuser_d  = 1'b0;
                        done_d   = 1'b1;
                        count_d  = count_q + CNT_WIDTH'(1);
                    end else begin
                        // Not last, so len_q >= 2 and len_q-1 cannot underflow.
                        beat_d  = beat_next;
                        tdata_d = tdata_q + DATA_WIDTH'(1);
                        tlast_d = (beat_next == len_q - LEN_WIDTH'(1));
                        tuser_d = bad_q && (beat_next == len_q - LEN_WIDTH'(1));
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            len_q     <= '0;
            beat_q    <= '0;
            bad_q     <= 1'b0;
            tvalid_q  <= 1'b0;
            tlast_q   <= 1'b0;
            tuser_q   <= 1'b0;
            done_q    <= 1'b0;
            len_err_q <= 1'b0;
            count_q   <= '0;
        end else begin
            state_q   <= state_d;
            len_q     <= len_d;
            beat_q    <= beat_d;
            bad_q     <= bad_d;
            tvalid_q  <= tvalid_d;
            tlast_q   <= tlast_d;
            tuser_q   <= tuser_d;
            done_q    <= done_d;
            len_err_q <= len_err_d;
            count_q   <= count_d;
        end
    end

    // Payload and sideband registers carry no reset; they are qualified by tvalid.
    always_ff @(posedge clk) begin
        tdata_q <= tdata_d;
        tid_q   <= tid_d;
        tdest_q <= tdest_d;
    end

    assign cmd_ready         = (state_q == IDLE);
    assign busy              = (state_q == SEND);
    assign m_axis_tvalid     = tvalid_q;
    assign m_axis_tdata      = tdata_q;
    assign m_axis_tkeep      = '1;
    assign m_axis_tlast      = tlast_q;
    assign m_axis_tuser      = tuser_q;
    assign m_axis_tid        = tid_q;
    assign m_axis_tdest      = tdest_q;
    assign status_frame_done = done_q;
    assign status_len_error  = len_err_q;
    assign frame_count       = count_q;

endmodule

// File: tb/tb_axis_frame_gen.sv
// Bench for axis_frame_gen: directed and random frames checked against an arithmetic model
// of the expected beat sequence, with a short length field and counter to reach wrap cases.
module tb_axis_frame_gen;

    localparam int DW = 8;
    localparam int KW = 1;
    localparam int IW = 8;
    localparam int DSW = 8;
    localparam int LW = 8;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          cmd_valid;
    logic          cmd_ready;
    logic [LW-1:0] cmd_len;
    logic [DW-1:0] cmd_seed;
    logic [IW-1:0] cmd_id;
    logic [DSW-1:0] cmd_dest;
    logic          cmd_bad;
    logic [DW-1:0] tdata;
    logic [KW-1:0] tkeep;
    logic          tvalid;
    logic          tready;
    logic          tlast;
    logic [IW-1:0] tid;
    logic [DSW-1:0] tdest;
    logic          tuser;
    logic          busy;
    logic          done;
    logic          len_err;
    logic [CW-1:0] frame_count;

    int total = 0;
    int bad = 0;
    int model_cnt = 0;

    axis_frame_gen #(
        .DATA_WIDTH(DW), .KEEP_WIDTH(KW), .ID_WIDTH(IW), .DEST_WIDTH(DSW),
        .LEN_WIDTH(LW), .CNT_WIDTH(CW)
    ) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_len(cmd_len),
        .cmd_seed(cmd_seed), .cmd_id(cmd_id), .cmd_dest(cmd_dest), .cmd_bad(cmd_bad),
        .m_axis_tdata(tdata), .m_axis_tkeep(tkeep), .m_axis_tvalid(tvalid),
        .m_axis_tready(tready), .m_axis_tlast(tlast), .m_axis_tid(tid),
        .m_axis_tdest(tdest), .m_axis_tuser(tuser), .busy(busy),
        .status_frame_done(done), .status_len_error(len_err), .frame_count(frame_count)
    );

    always #5 clk = ~clk;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish, observed=running expected=finished");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(negedge clk);
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] exp_count();
        return 64'(model_cnt % (1 << CW));
    endfunction

    // Runs one frame; rmode 0 = always ready, 1 = random ready, 2 = ready pattern 1,0,0.
    task automatic do_frame(input int len, input logic [DW-1:0] seed, input logic [IW-1:0] id,
                            input logic [DSW-1:0] dest, input bit badf, input int rmode);
        int beat = 0;
        int cyc = 0;
        int max_cyc = len * 4 + 20;
        bit stalled = 1'b0;
        logic [DW-1:0] p_data;
        logic p_last, p_user;
        logic [IW-1:0] p_id;
        logic [DSW-1:0] p_dest;
        bit is_last;

        cmd_valid = 1'b1;
        cmd_len   = LW'(len);
        cmd_seed  = seed;
        cmd_id    = id;
        cmd_dest  = dest;
        cmd_bad   = badf;
        tready    = 1'b1;
        check("cmd_ready_idle", 64'(cmd_ready), 64'd1);
        step();

        while (beat < len && cyc < max_cyc) begin
            // Command inputs are noise while the frame is in flight.
            cmd_valid = 1'($urandom_range(0, 1));
            cmd_len   = LW'($urandom);
            cmd_seed  = DW'($urandom);
            cmd_id    = IW'($urandom);
            cmd_dest  = DSW'($urandom);
            cmd_bad   = 1'($urandom_range(0, 1));
            case (rmode)
                0: tready = 1'b1;
                1: tready = 1'($urandom_range(0, 1));
                default: tready = (cyc % 3 == 0);
            endcase
            check("tvalid_in_frame", 64'(tvalid), 64'd1);
            check("busy_in_frame", 64'(busy), 64'd1);
            check("len_err_in_frame", 64'(len_err), 64'd0);
            if (stalled) begin
                check("stall_tdata", 64'(tdata), 64'(p_data));
                check("stall_tlast", 64'(tlast), 64'(p_last));
                check("stall_tuser", 64'(tuser), 64'(p_user));
                check("stall_tid", 64'(tid), 64'(p_id));
                check("stall_tdest", 64'(tdest), 64'(p_dest));
            end
            if (tvalid && tready) begin
                is_last = (beat == len - 1);
                check("beat_tdata", 64'(tdata), 64'((int'(seed) + beat) % 256));
                check("beat_tlast", 64'(tlast), 64'(is_last));
                check("beat_tuser", 64'(tuser), 64'(badf && is_last));
                check("beat_tkeep", 64'(tkeep), 64'd1);
                check("beat_tid", 64'(tid), 64'(id));
                check("beat_tdest", 64'(tdest), 64'(dest));
                beat++;
            end
            stalled = tvalid && !tready;
            p_data = tdata; p_last = tlast; p_user = tuser; p_id = tid; p_dest = tdest;
            cyc++;
            step();
        end
        cmd_valid = 1'b0;
        tready = 1'b1;
        check("frame_handshakes", 64'(beat), 64'(len));
        model_cnt++;
        check("post_tvalid", 64'(tvalid), 64'd0);
        check("post_busy", 64'(busy), 64'd0);
        check("post_done", 64'(done), 64'd1);
        check("post_count", 64'(frame_count), exp_count());
        step();
        check("done_single_pulse", 64'(done), 64'd0);
        $display("frame len=%0d seed=%0h bad=%0d rmode=%0d cycles=%0d count=%0d",
                 len, seed, badf, rmode, cyc, frame_count);
    endtask

    initial begin
        rst = 1'b1;
        cmd_valid = 1'b0;
        cmd_len = '0;
        cmd_seed = '0;
        cmd_id = '0;
        cmd_dest = '0;
        cmd_bad = 1'b0;
        tready = 1'b0;
        repeat (3) step();
        check("rst_tvalid", 64'(tvalid), 64'd0);
        check("rst_tlast", 64'(tlast), 64'd0);
        check("rst_tuser", 64'(tuser), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_len_err", 64'(len_err), 64'd0);
        check("rst_count", 64'(frame_count), 64'd0);
        check("rst_cmd_ready", 64'(cmd_ready), 64'd1);
        rst = 1'b0;
        step();

        do_frame(4, 8'h10, 8'd3, 8'd5, 1'b0, 0);
        do_frame(3, 8'hFE, 8'd1, 8'd2, 1'b1, 0);
        do_frame(5, 8'h20, 8'd7, 8'd9, 1'b0, 2);
        do_frame(1, 8'h77, 8'd4, 8'd6, 1'b1, 1);

        // Zero-length command is consumed and flagged without producing a beat.
        cmd_valid = 1'b1; cmd_len = '0; cmd_seed = 8'h99;
        step();
        cmd_valid = 1'b0;
        check("len0_err_pulse", 64'(len_err), 64'd1);
        check("len0_tvalid", 64'(tvalid), 64'd0);
        check("len0_ready", 64'(cmd_ready), 64'd1);
        check("len0_count", 64'(frame_count), exp_count());
        step();
        check("len0_err_single", 64'(len_err), 64'd0);
        check("len0_tvalid_after", 64'(tvalid), 64'd0);
        $display("len0 command count=%0d", frame_count);

        // Back-to-back len=2 frames with cmd_valid held high.
        cmd_valid = 1'b1; cmd_len = 8'd2; cmd_seed = 8'h40; cmd_id = 8'd1; cmd_dest = 8'd1;
        cmd_bad = 1'b0; tready = 1'b1;
        step();
        check("b2b_f1_b0_valid", 64'(tvalid), 64'd1);
        check("b2b_f1_b0_data", 64'(tdata), 64'h40);
        check("b2b_f1_b0_last", 64'(tlast), 64'd0);
        step();
        check("b2b_f1_b1_data", 64'(tdata), 64'h41);
        check("b2b_f1_b1_last", 64'(tlast), 64'd1);
        step();
        model_cnt++;
        check("b2b_gap_valid", 64'(tvalid), 64'd0);
        check("b2b_gap_ready", 64'(cmd_ready), 64'd1);
        check("b2b_gap_done", 64'(done), 64'd1);
        step();
        cmd_valid = 1'b0;
        check("b2b_f2_b0_valid", 64'(tvalid), 64'd1);
        check("b2b_f2_b0_data", 64'(tdata), 64'h40);
        step();
        check("b2b_f2_b1_data", 64'(tdata), 64'h41);
        check("b2b_f2_b1_last", 64'(tlast), 64'd1);
        step();
        model_cnt++;
        check("b2b_end_valid", 64'(tvalid), 64'd0);
        check("b2b_end_count", 64'(frame_count), exp_count());
        $display("back-to-back len=2 x2 count=%0d", frame_count);

        // Maximum length frame, payload wraps through 0xFF.
        do_frame((1 << LW) - 1, 8'hF0, 8'd2, 8'd8, 1'b1, 0);

        // Reset while the third beat of an 8-beat frame is presented.
        cmd_valid = 1'b1; cmd_len = 8'd8; cmd_seed = 8'h55; cmd_bad = 1'b1; tready = 1'b1;
        step();
        cmd_valid = 1'b0;
        check("rstmid_b0", 64'(tdata), 64'h55);
        step();
        check("rstmid_b1", 64'(tdata), 64'h56);
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        model_cnt = 0;
        check("rstmid_tvalid", 64'(tvalid), 64'd0);
        check("rstmid_tlast", 64'(tlast), 64'd0);
        check("rstmid_busy", 64'(busy), 64'd0);
        check("rstmid_count", 64'(frame_count), 64'd0);
        check("rstmid_ready", 64'(cmd_ready), 64'd1);
        check("rstmid_done", 64'(done), 64'd0);
        step();
        check("rstmid_idle_valid", 64'(tvalid), 64'd0);
        $display("reset mid-frame count=%0d", frame_count);
        do_frame(3, 8'h30, 8'd9, 8'd10, 1'b0, 0);

        // Random frames; more than 2^CW of them so frame_count wraps.
        for (int n = 0; n < 20; n++) begin
            do_frame($urandom_range(1, 20), DW'($urandom), IW'($urandom), DSW'($urandom),
                     1'($urandom_range(0, 1)), $urandom_range(0, 2));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/axis_frame_gen.md
AXIS_FRAME_GEN -- requirements
Module: axis_frame_gen

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, tdata width in bits (multiple of 8).
REQ-002 SHALL have parameter KEEP_WIDTH, default DATA_WIDTH/8, tkeep width.
REQ-003 SHALL have parameter ID_WIDTH, default 8, tid width.
REQ-004 SHALL have parameter DEST_WIDTH, default 8, tdest width.
REQ-005 SHALL have parameter LEN_WIDTH, default 16, frame length field width (in beats).
REQ-006 SHALL have parameter CNT_WIDTH, default 32, frame counter width.
REQ-007 SHALL have ports, one per line:
- clk  input  1  clock, all logic on rising edge
- rst  input  1  reset, synchronous, active-high
- cmd_valid  input  1  command present
- cmd_ready  output  1  command accepted when high with cmd_valid
- cmd_len  input  LEN_WIDTH  frame length in beats
- cmd_seed  input  DATA_WIDTH  tdata value of first beat
- cmd_id  input  ID_WIDTH  tid for whole frame
- cmd_dest  input  DEST_WIDTH  tdest for whole frame
- cmd_bad  input  1  mark frame bad via tuser on last beat
- m_axis_tdata  output  DATA_WIDTH  stream data
- m_axis_tkeep  output  KEEP_WIDTH  byte enables
- m_axis_tvalid  output  1  beat valid
- m_axis_tready  input  1  downstream ready
- m_axis_tlast  output  1  last beat of frame
- m_axis_tid  output  ID_WIDTH  stream id
- m_axis_tdest  output  DEST_WIDTH  stream destination
- m_axis_tuser  output  1  bad-frame flag
- busy  output  1  frame in progress
- status_frame_done  output  1  one-cycle pulse per completed frame
- status_len_error  output  1  one-cycle pulse per rejected zero-length command
- frame_count  output  CNT_WIDTH  completed frames since reset

Function
REQ-008 SHALL implement FSM states IDLE and SEND; cmd_ready SHALL equal (state==IDLE).
REQ-009 In IDLE, cmd_valid with cmd_len!=0 SHALL latch cmd_len/seed/id/dest/bad, clear beat counter, enter SEND; m_axis_tvalid SHALL rise the next cycle (1-cycle latency).
REQ-010 In IDLE, cmd_valid with cmd_len==0 SHALL be consumed, pulse status_len_error next cycle, remain IDLE, emit no beat.
REQ-011 In SEND, m_axis_tvalid SHALL be 1; beat i (0-based) SHALL carry tdata = (seed + i) mod 2^DATA_WIDTH, tkeep all ones, tid/tdest latched values.
REQ-012 tlast SHALL be 1 only on beat i = len-1; tuser SHALL equal latched cmd_bad on that beat and 0 otherwise.
REQ-013 All m_axis outputs SHALL be registered and held stable while tvalid=1 and tready=0.
REQ-014 A beat SHALL advance only on tvalid&&tready; beat counter SHALL be LEN_WIDTH bits and never wrap within a frame.
REQ-015 On acceptance of the last beat: return to IDLE, tvalid=0 next cycle, status_frame_done pulse next cycle, frame_count increment.
REQ-016 Consecutive frames SHALL be separated by exactly one IDLE cycle when cmd_valid is held high.
REQ-017 frame_count SHALL wrap from 2^CNT_WIDTH-1 to 0.
REQ-018 busy SHALL equal (state==SEND).
REQ-019 cmd_len=2^LEN_WIDTH-1 SHALL produce exactly that many beats; tdata SHALL wrap mod 2^DATA_WIDTH within a frame.
REQ-020 Command inputs SHALL be ignored while in SEND.

Reset
REQ-021 rst SHALL force IDLE; m_axis_tvalid=0, m_axis_tlast=0, m_axis_tuser=0, busy=0, status_frame_done=0, status_len_error=0, frame_count=0, cmd_ready=1 in the cycle after rst is sampled high.
REQ-022 rst mid-frame SHALL abandon the frame without asserting tlast; frame_count SHALL not increment.
REQ-023 tdata/tkeep/tid/tdest need no reset value.

Verification
REQ-024 len=4, seed=0x10, id=3, dest=5, bad=0, tready=1 -> tdata 0x10,0x11,0x12,0x13 on four consecutive cycles, tlast on 0x13, tuser=0, frame_count=1.
REQ-025 len=3, seed=0xFE, bad=1 -> tdata 0xFE,0xFF,0x00; tuser=1 only with tlast; status_frame_done one pulse.
REQ-026 len=5, tready toggled 1,0,0,1,... -> every beat held stable during stall; exactly 5 handshakes, no duplicate/skipped value.
REQ-027 len=0 -> status_len_error one pulse, tvalid stays 0, frame_count unchanged.
REQ-028 cmd_valid held with len=2 twice -> frames 2 beats each, one idle cycle between, frame_count=2.
REQ-029 rst asserted after beat 2 of len=8 -> tvalid=0 next cycle, frame_count=0, next command starts at its seed.
